wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
- Pipelined Wishbone responder fronting an internal synchronous word RAM; attaches to the slave modport of the codebase's if_wb interface.
- Serves the existing bus masters as a general scratch/boot memory.
- Supports byte-lane writes and programmable wait states.
- Fully pipelined (one access per clock) when WAIT_STATES=0.

Parameters:
- AWIDTH, 32: bus address width (byte address).
- DWIDTH, 32: bus data width. Must be 32, since sel is 4 bits.
- DEPTH, 1024: RAM depth in 32-bit words. Power of two.
- WAIT_STATES, 0: extra cycles inserted between accept and ack. Range 0..15.

Ports:
- clk_i  input  1  bus clock. All logic is on the rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- bus  if_wb.slave  —  Wishbone slave modport:
  - adr/cyc/stb/we/sel/dat_i: inputs.
  - ack/stall/dat_o: outputs.

Behaviour:
- Reset (rst_n_i=0): ack=0, stall=0, dat_o=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Accept condition: cyc & stb & !stall at a rising edge.
- Word index: adr[$clog2(DEPTH)+1:2]. adr[1:0] and bits above the index are ignored, so out-of-range addresses alias (wrap).
- Write: on the accept edge, each byte lane i with sel[i]=1 is written from dat_i. Lanes with sel[i]=0 are unchanged. The write commits at accept, even if the cycle is later aborted.
- Read: RAM word is captured at the accept edge and held in dat_o until the next ack. dat_o is don't-care when ack=0, but is held stable in the implementation.
- Write acks drive dat_o with the post-write word.
- FSM states:
  - IDLE: no pending access.
  - WAIT: counter counting down WAIT_STATES.
  - ACK: ack=1 this cycle.
- WAIT_STATES=0:
  - Accept -> ACK on the next cycle. ack is high exactly one cycle after each accept.
  - Back-to-back accepts give a continuous ack stream; stall is always 0.
- WAIT_STATES=N>0:
  - Accept -> WAIT with counter=N. stall=1 throughout WAIT.
  - Counter reaches 1 -> ACK. ack is high in cycle accept+N+1.
  - In ACK, stall=0, so a new accept may occur in the same cycle as the ack (overlap).
  - ACK with no new accept -> IDLE.
- Exactly one ack per accepted strobe; acks are in order.
- ack is never asserted while cyc=0.
- cyc deasserted while in WAIT or ACK: pending ack is cancelled, FSM -> IDLE, stall -> 0 next cycle.
- stb while stall=1 is ignored (not accepted, no ack).
- Async reset mid-access: all state clears immediately and the pending ack is lost. A write accepted before reset stays in RAM.

Optional Feature:
- Macro: WB_SRAM_REGOUT_EN.
- Defined: adds an output register stage on dat_o and ack. Every ack (and its data) comes one cycle later than the base timing. Stall timing is unchanged. A cyc drop also clears the output stage.
- Undefined: base latency as in Behaviour.

Decomposition:
- Package wb_pkg:
  - typedef wb_state_t {IDLE, WAIT, ACK}.
  - localparam WB_SEL_W=4.
  - function wb_byte_merge(old, new, sel).
- Sub-module sram_bw: single-port byte-write synchronous RAM (DEPTH x 32, we, sel, read-during-write returns new data).
- Top level holds the FSM, wait counter, and ack/stall/cyc-abort logic.

Test Plan:
- Reset release with W=0; single write adr=0x10, dat=0xDEADBEEF, sel=0xF, then read 0x10 -> ack one cycle after each accept, read dat_o=0xDEADBEEF, stall never 1.
- W=0, four back-to-back reads 0x0,0x4,0x8,0xC preloaded with 1..4 -> ack high four consecutive cycles, dat_o sequence 1,2,3,4.
- Byte lanes: word=0x11223344, write sel=0x5 dat=0xAABBCCDD -> read returns 0x11BB33DD.
- W=3: accept at cycle t -> stall=1 in t+1..t+3, ack at t+4; new stb held from t+1 is accepted at t+4 and acked at t+8.
- W=3: drop cyc at t+2 -> no ack, stall=0 at t+3; a prior write of 0x55 to that address reads back 0x55.
- Aliasing with DEPTH=1024: write 0xCAFE0000 to adr=0x0000_1004, read adr=0x4 -> 0xCAFE0000. Repeat with WB_SRAM_REGOUT_EN defined -> ack one cycle later than the W=0 case.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone SRAM types and helpers: FSM state encoding and byte-lane merge.
package wb_pkg;

  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

  function automatic logic [31:0] wb_byte_merge(input logic [31:0]         old_word,
                                                input logic [31:0]         new_word,
                                                input logic [WB_SEL_W-1:0] sel);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle; dat_i/dat_o are named from the slave's point of view.
interface if_wb
  import wb_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);

  logic [AWIDTH-1:0]   adr;
  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_SEL_W-1:0] sel;
  logic [DWIDTH-1:0]   dat_i;
  logic [DWIDTH-1:0]   dat_o;
  logic                ack;
  logic                stall;

  modport master (
    output adr, cyc, stb, we, sel, dat_i,
    input  ack, stall, dat_o
  );

  modport slave (
    input  adr, cyc, stb, we, sel, dat_i,
    output ack, stall, dat_o
  );

endinterface

// File: rtl/sram_bw.sv
// Single-port byte-write synchronous RAM; a write returns the merged (post-write) word.
module sram_bw
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [WB_SEL_W-1:0] i_sel,
  input  logic [AW-1:0]       i_addr,
  input  logic [31:0]         i_wdata,
  output logic [31:0]         o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  always_comb begin
    w_merged = wb_byte_merge(r_mem[i_addr], i_wdata, i_sel);
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) r_mem[i_addr] <= w_merged;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= i_we ? w_merged : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_sram_slave.sv
// Pipelined Wishbone SRAM responder with programmable wait states.
// Define WB_SRAM_REGOUT_EN to add an extra register stage on ack/dat_o.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic clk_i,
  input logic rst_n_i,
  if_wb.slave bus
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  wb_state_t         r_state;
  logic [3:0]        r_cnt;
  logic              r_ack;
  logic              r_stall;
  logic              w_accept;
  logic [IDX_W-1:0]  w_idx;
  logic [DWIDTH-1:0] w_rdata;
  logic              w_unused_adr;

  assign w_accept     = bus.cyc & bus.stb & ~r_stall;
  assign w_idx        = bus.adr[IDX_W+1:2];
  assign w_unused_adr = ^{bus.adr[AWIDTH-1:IDX_W+2], bus.adr[1:0]};

  sram_bw #(
    .DEPTH (DEPTH)
  ) u_sram (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_en    (w_accept),
    .i_we    (bus.we),
    .i_sel   (bus.sel),
    .i_addr  (w_idx),
    .i_wdata (bus.dat_i),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_stall <= 1'b0;
    end else if (!bus.cyc) begin
      // Master abandoned the cycle: drop any pending response.
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_stall <= 1'b0;
    end else if (w_accept) begin
      if (WAIT_STATES == 0) begin
        r_state <= ACK;
        r_ack   <= 1'b1;
        r_stall <= 1'b0;
      end else begin
        r_state <= WAIT;
        r_cnt   <= WAIT_INIT;
        r_ack   <= 1'b0;
        r_stall <= 1'b1;
      end
    end else begin
      unique case (r_state)
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= ACK;
            r_cnt   <= '0;
            r_ack   <= 1'b1;
            r_stall <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_ack <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall = r_stall;

`ifdef WB_SRAM_REGOUT_EN
  logic              r_ack_q;
  logic [DWIDTH-1:0] r_dat_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ack_q <= 1'b0;
      r_dat_q <= '0;
    end else if (!bus.cyc) begin
      r_ack_q <= 1'b0;
    end else begin
      r_ack_q <= r_ack;
      if (r_ack) r_dat_q <= w_rdata;
    end
  end

  assign bus.ack   = r_ack_q & bus.cyc;
  assign bus.dat_o = r_dat_q;
`else
  // Gating with cyc keeps ack low in the very cycle the master drops cyc.
  assign bus.ack   = r_ack & bus.cyc;
  assign bus.dat_o = w_rdata;
`endif

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: one zero-wait and one three-wait instance sharing stimulus.
module tb_wb_sram_slave;

`ifdef WB_SRAM_REGOUT_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int LAT0 = 1 + R;
  localparam int LAT3 = 4 + R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc0 = 1'b0;
  logic        cyc3 = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;

  always #5 clk = ~clk;

  if_wb bus0 ();
  if_wb bus3 ();

  assign bus0.cyc = cyc0;  assign bus0.stb = stb;  assign bus0.we = we;
  assign bus0.adr = adr;   assign bus0.dat_i = dat; assign bus0.sel = sel;
  assign bus3.cyc = cyc3;  assign bus3.stb = stb;  assign bus3.we = we;
  assign bus3.adr = adr;   assign bus3.dat_i = dat; assign bus3.sel = sel;

  wb_sram_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus0)
  );

  wb_sram_slave #(.AWIDTH(32), .DWIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit stall0_seen = 1'b0;

  always @(negedge clk) if (bus0.stall !== 1'b0 && rst_n) stall0_seen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on either instance; returns data and ack latency in cycles (-1 on timeout).
  task automatic single(input bit u3, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
    if (u3) cyc3 = 1'b1; else cyc0 = 1'b1;
    stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    lat = -1; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((u3 ? bus3.ack : bus0.ack) === 1'b1) begin
        lat = i;
        rd  = u3 ? bus3.dat_o : bus0.dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    cyc0 = 1'b0; cyc3 = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } pend_t;

  vec_t        tbl [10];
  pend_t       q [$];
  logic [31:0] mdl [16];
  logic [31:0] rd;
  int          lat;
  logic        s_ack [12];
  logic        s_stall [12];
  logic [31:0] s_dat [12];
  logic [31:0] r;
  int          idx;
  bit          exp_ack;
  bit          ack_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h11223344};
    tbl[3] = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h11BB33DD};
    tbl[4] = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD};
    tbl[5] = '{1'b1, 32'h1004, 32'hCAFE0000, 4'hF, 32'hCAFE0000};
    tbl[6] = '{1'b0, 32'h4,    32'h0,        4'hF, 32'hCAFE0000};
    tbl[7] = '{1'b1, 32'h28,   32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    tbl[8] = '{1'b1, 32'h2B,   32'h01020304, 4'hA, 32'h01FF03FF};
    tbl[9] = '{1'b1, 32'h10,   32'h12345678, 4'h0, 32'hDEADBEEF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", bus0.ack, 0);   chk("rst_stall0", bus0.stall, 0);
    chk("rst_dat0", bus0.dat_o, 0); chk("rst_ack3", bus3.ack, 0);
    chk("rst_stall3", bus3.stall, 0); chk("rst_dat3", bus3.dat_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      single(1'b0, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, lat);
      chk($sformatf("vec%0d_dat", i), rd, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, LAT0);
    end

    // Back-to-back reads on the zero-wait instance.
    for (int i = 0; i < 4; i++) single(1'b0, 1'b1, 32'(4 * i), 32'(i + 1), 4'hF, rd, lat);
    cyc0 = 1'b1;
    for (int i = 0; i < 4 + LAT0 + 2; i++) begin
      stb = (i < 4); we = 1'b0; sel = 4'hF; adr = 32'(4 * i);
      @(negedge clk);
      s_ack[i] = bus0.ack; s_dat[i] = bus0.dat_o;
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc0 = 1'b0;
    for (int i = 0; i < 4 + LAT0 + 2; i++) begin
      exp_ack = (i >= LAT0) && (i < LAT0 + 4);
      chk($sformatf("b2b_ack%0d", i), s_ack[i], exp_ack);
      if (exp_ack) chk($sformatf("b2b_dat%0d", i), s_dat[i], 32'(i - LAT0 + 1));
    end

    // Wait-state timing with an overlapping second strobe.
    single(1'b1, 1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, rd, lat);
    chk("w3_wr_lat", lat, LAT3);
    chk("w3_wr_dat", rd, 32'hA0A0A0A0);
    single(1'b1, 1'b1, 32'h44, 32'hB4B4B4B4, 4'hF, rd, lat);
    chk("w3_wr2_lat", lat, LAT3);
    cyc3 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      stb = (i <= 4); we = 1'b0; sel = 4'hF; adr = (i == 0) ? 32'h40 : 32'h44;
      @(negedge clk);
      s_ack[i] = bus3.ack; s_stall[i] = bus3.stall; s_dat[i] = bus3.dat_o;
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("w3_stall%0d", i), s_stall[i], ((i >= 1 && i <= 3) || (i >= 5 && i <= 7)));
      chk($sformatf("w3_ack%0d", i), s_ack[i], (i == 4 + R) || (i == 8 + R));
      if (i == 4 + R) chk("w3_dat_a", s_dat[i], 32'hA0A0A0A0);
      if (i == 8 + R) chk("w3_dat_b", s_dat[i], 32'hB4B4B4B4);
    end

    // cyc abort mid-wait: no ack, stall clears, write still commits.
    single(1'b1, 1'b1, 32'h48, 32'h11, 4'hF, rd, lat);
    for (int i = 0; i < 8; i++) begin
      cyc3 = (i <= 1); stb = (i == 0); we = (i == 0); adr = 32'h48; dat = 32'h55; sel = 4'hF;
      @(negedge clk);
      s_ack[i] = bus3.ack; s_stall[i] = bus3.stall;
      @(posedge clk); #1;
    end
    stb = 1'b0; we = 1'b0; cyc3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("abort_stall%0d", i), s_stall[i], (i == 1 || i == 2));
      chk($sformatf("abort_ack%0d", i), s_ack[i], 0);
    end
    single(1'b1, 1'b0, 32'h48, 32'h0, 4'hF, rd, lat);
    chk("abort_rd_dat", rd, 32'h55);
    chk("abort_rd_lat", lat, LAT3);

    // Asynchronous reset in the middle of a waited write.
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4C; dat = 32'h77; sel = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", bus3.stall, 0);
    chk("arst_ack", bus3.ack, 0);
    chk("arst_dat", bus3.dat_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus3.ack !== 1'b0) ack_seen = 1'b1;
    end
    @(posedge clk); #1;
    cyc3 = 1'b0;
    chk("arst_no_ack", ack_seen, 0);
    single(1'b1, 1'b0, 32'h4C, 32'h0, 4'hF, rd, lat);
    chk("arst_rd_dat", rd, 32'h77);

    // Randomised traffic on the zero-wait instance against a word-array model.
    for (int k = 0; k < 16; k++) begin
      mdl[k] = $urandom;
      single(1'b0, 1'b1, 32'(k * 4), mdl[k], 4'hF, rd, lat);
    end
    for (int n = 0; n < 400 + LAT0 + 2; n++) begin
      if (n < 400) begin
        cyc0 = ($urandom_range(0, 9) != 0);
        stb  = 1'($urandom_range(0, 1));
        we   = 1'($urandom_range(0, 1));
        sel  = 4'($urandom_range(0, 15));
        dat  = $urandom;
        r    = $urandom;
        idx  = $urandom_range(0, 15);
        adr  = (r & 32'hFFFFF000) | (32'(idx) << 2) | (r & 32'h3);
      end else begin
        cyc0 = 1'b1; stb = 1'b0;
      end
      @(negedge clk);
      if (!cyc0) q.delete();
      exp_ack = (q.size() > 0) && (q[0].due == n);
      chk("rnd_ack", bus0.ack, exp_ack);
      if (exp_ack) begin
        chk("rnd_dat", bus0.dat_o, q[0].d);
        void'(q.pop_front());
      end
      if (cyc0 && stb) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (sel[b]) mdl[idx][8*b +: 8] = dat[8*b +: 8];
        end
        q.push_back('{n + LAT0, mdl[idx]});
      end
      @(posedge clk); #1;
    end
    cyc0 = 1'b0;
    chk("rnd_drained", q.size(), 0);
    chk("stall0_never", stall0_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
